// File: rtl/sample_ram_arb.sv
// sample_ram_arb: two-master pipelined-Wishbone arbiter for the shared sample RAM.
// S0 (sniffer capture writer) has fixed priority over S1 (FTDI host bus).
// Only one transaction is outstanding at a time. A sticky timeout flags an ack that never arrived.
// Optional build macro SAMPLE_ARB_FAIR_EN adds a bounded-starvation guarantee for S1.
// Once S0 has overtaken a waiting S1 MAX_WAIT times, S1 is granted.
module sample_ram_arb #(
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] s0_addr_i,
  input  logic [31:0] s0_data_i,
  input  logic [3:0]  s0_sel_i,
  input  logic        s0_we_i,
  input  logic        s0_stb_i,
  output logic        s0_stall_o,
  output logic        s0_ack_o,
  input  logic [31:0] s1_addr_i,
  input  logic [31:0] s1_data_i,
  output logic [31:0] s1_data_o,
  input  logic [3:0]  s1_sel_i,
  input  logic        s1_we_i,
  input  logic        s1_stb_i,
  output logic        s1_stall_o,
  output logic        s1_ack_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_data_o,
  output logic [3:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_stb_o,
  input  logic [31:0] m_data_i,
  input  logic        m_stall_i,
  input  logic        m_ack_i,
  output logic        timeout_o,
  input  logic        timeout_clr_i
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_S0 = 2'd1;
  localparam logic [1:0] ST_WAIT_S1 = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s0_ack_q, s0_ack_d;
  logic             s1_ack_q, s1_ack_d;
  logic             timeout_q, timeout_d;
  logic [31:0]      s1_data_q, s1_data_d;

  logic             s1_force_c;
  logic             grant_s1_c;
  logic             req_c;
  logic             issue_c;

  // S1 wins only when S0 is absent or when fairness forces the grant.
  assign grant_s1_c = s1_stb_i & (~s0_stb_i | s1_force_c);
  assign req_c      = (state_q == ST_IDLE) & (s0_stb_i | s1_stb_i);
  assign issue_c    = req_c & ~m_stall_i;

`ifdef SAMPLE_ARB_FAIR_EN
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] wait_q, wait_d;

  // Count S0 issues that overtake a pending S1, saturating at MAX_WAIT.
  always_comb begin
    wait_d = wait_q;
    if (!s1_stb_i || (issue_c && grant_s1_c)) begin
      wait_d = '0;
    end else if (issue_c && (wait_q != WAIT_W'(MAX_WAIT))) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  // Wait counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign s1_force_c = (wait_q == WAIT_W'(MAX_WAIT));
`else
  logic unused_max_wait;

  // Strict priority: S1 is never forced; the fairness limit is only referenced.
  assign unused_max_wait = |MAX_WAIT;
  assign s1_force_c      = 1'b0;
`endif

  // Request mux toward the RAM plus stall steering; the loser always sees stall.
  always_comb begin
    m_addr_o   = '0;
    m_data_o   = '0;
    m_sel_o    = '0;
    m_we_o     = 1'b0;
    m_stb_o    = 1'b0;
    s0_stall_o = 1'b1;
    s1_stall_o = 1'b1;
    if (req_c) begin
      m_stb_o = 1'b1;
      if (grant_s1_c) begin
        m_addr_o   = s1_addr_i;
        m_data_o   = s1_data_i;
        m_sel_o    = s1_sel_i;
        m_we_o     = s1_we_i;
        s1_stall_o = m_stall_i;
      end else begin
        m_addr_o   = s0_addr_i;
        m_data_o   = s0_data_i;
        m_sel_o    = s0_sel_i;
        m_we_o     = s0_we_i;
        s0_stall_o = m_stall_i;
      end
    end
  end

  // Next state: issue, ack or timeout completion, sticky timeout flag.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    s0_ack_d  = 1'b0;
    s1_ack_d  = 1'b0;
    s1_data_d = s1_data_q;
    timeout_d = timeout_q & ~timeout_clr_i;
    case (state_q)
      ST_IDLE: begin
        if (issue_c) begin
          state_d = grant_s1_c ? ST_WAIT_S1 : ST_WAIT_S0;
          cnt_d   = '0;
        end
      end
      ST_WAIT_S0, ST_WAIT_S1: begin
        if (m_ack_i) begin
          state_d = ST_IDLE;
          if (state_q == ST_WAIT_S1) begin
            s1_ack_d  = 1'b1;
            s1_data_d = m_data_i;
          end else begin
            s0_ack_d = 1'b1;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Lost ack: complete the transfer anyway so the master is not hung.
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
          if (state_q == ST_WAIT_S1) begin
            s1_ack_d  = 1'b1;
            s1_data_d = '0;
          end else begin
            s0_ack_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered-output flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      s0_ack_q  <= 1'b0;
      s1_ack_q  <= 1'b0;
      s1_data_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s0_ack_q  <= s0_ack_d;
      s1_ack_q  <= s1_ack_d;
      s1_data_q <= s1_data_d;
      timeout_q <= timeout_d;
    end
  end

  assign s0_ack_o  = s0_ack_q;
  assign s1_ack_o  = s1_ack_q;
  assign s1_data_o = s1_data_q;
  assign timeout_o = timeout_q;

endmodule
